// File: rtl/bkm_e_iter.sv
// Sequential BKM E-mode engine: E(n+1) = E(n) * (1 + (d_x + j*d_y) * 2^-n), n = 1..N.
// The current index is published on n_out so the digit selector can answer in the same cycle.
module bkm_e_iter #(
  parameter int W        = 8,
  parameter int N        = 8,
  parameter int CNT_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  input  logic [W-1:0]        x_in,
  input  logic [W-1:0]        y_in,
  input  logic [1:0]          d_x,
  input  logic [1:0]          d_y,
  output logic [CNT_SIZE-1:0] n_out,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        x_out,
  output logic [W-1:0]        y_out,
  output logic                ovf,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [CNT_SIZE-1:0]  n;
  logic signed [W-1:0]  x, y;
  logic signed [W+1:0]  tx, ty, sx, sy;

  function automatic logic signed [W+1:0] ext(input logic signed [W-1:0] v);
    return {{2{v[W-1]}}, v};
  endfunction

  // Digit "multiply": 01 -> +v, 11 -> -v, 00 and the illegal 10 -> 0.
  function automatic logic signed [W+1:0] dmul(input logic [1:0] d, input logic signed [W-1:0] v);
    case (d)
      2'b01:   return ext(v);
      2'b11:   return -ext(v);
      default: return '0;
    endcase
  endfunction

  function automatic logic sat_hit(input logic signed [W+1:0] v);
    return !(v[W+1:W-1] == 3'b000 || v[W+1:W-1] == 3'b111);
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
    if (!sat_hit(v))  return v[W-1:0];
    else if (v[W+1])  return {1'b1, {(W-1){1'b0}}};
    else              return {1'b0, {(W-1){1'b1}}};
  endfunction

  always_comb begin
    tx = dmul(d_x, x) - dmul(d_y, y);
    ty = dmul(d_y, x) + dmul(d_x, y);
    sx = ext(x) + (tx >>> n);
    sy = ext(y) + (ty >>> n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      n     <= '0;
      x     <= '0;
      y     <= '0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            x     <= $signed(x_in);
            y     <= $signed(y_in);
            ovf   <= 1'b0;
            err   <= 1'b0;
            n     <= CNT_SIZE'(1);
            state <= RUN;
          end
        end
        RUN: begin
          x <= sat(sx);
          y <= sat(sy);
          if (sat_hit(sx) || sat_hit(sy)) ovf <= 1'b1;
          if (d_x == 2'b10 || d_y == 2'b10) err <= 1'b1;
          // n is cleared on the last iteration so n_out reads 0 outside RUN.
          if (n == CNT_SIZE'(N)) begin
            n     <= '0;
            state <= DONE;
          end else begin
            n <= n + CNT_SIZE'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign n_out = n;
  assign busy  = (state == RUN);
  assign done  = (state == DONE) && ena;
  assign x_out = x;
  assign y_out = y;

endmodule

// File: tb/tb_bkm_e_iter.sv
// Bench for bkm_e_iter: directed and random runs checked against an integer model of the BKM recurrence.
module tb_bkm_e_iter;
  localparam int W = 8;
  localparam int N = 8;
  localparam int CNT_SIZE = 4;

  logic                clk = 1'b0;
  logic                rst_n, ena, start;
  logic [W-1:0]        x_in, y_in;
  logic [1:0]          d_x, d_y;
  logic [CNT_SIZE-1:0] n_out;
  logic                busy, done, ovf, err;
  logic [W-1:0]        x_out, y_out;

  bkm_e_iter #(.W(W), .N(N), .CNT_SIZE(CNT_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .x_in(x_in), .y_in(y_in),
    .d_x(d_x), .d_y(d_y), .n_out(n_out), .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dxa[16], dya[16];   // digit per iteration: -1, 0, 1, or 2 meaning the illegal code 2'b10
  int stall_n, pulse_n;
  int mx, my;
  bit movf, merr;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] enc(input int v);
    case (v)
      -1:      return 2'b11;
      1:       return 2'b01;
      2:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int clamp(input int v, inout bit o);
    if (v > 127)  begin o = 1'b1; return 127;  end
    if (v < -128) begin o = 1'b1; return -128; end
    return v;
  endfunction

  task automatic model(input int x0, input int y0);
    int x, y, dx, dy, tx, ty, nx, ny;
    x = x0; y = y0; movf = 1'b0; merr = 1'b0;
    for (int n = 1; n <= N; n++) begin
      dx = dxa[n]; dy = dya[n];
      if (dx == 2) begin dx = 0; merr = 1'b1; end
      if (dy == 2) begin dy = 0; merr = 1'b1; end
      tx = dx * x - dy * y;
      ty = dy * x + dx * y;
      nx = clamp(x + (tx >>> n), movf);
      ny = clamp(y + (ty >>> n), movf);
      x = nx; y = ny;
    end
    mx = x; my = y;
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic clear_digits();
    for (int i = 0; i < 16; i++) begin dxa[i] = 0; dya[i] = 0; end
    stall_n = 0; pulse_n = 0;
  endtask

  task automatic run(input string name, input int x0, input int y0);
    int c, expn, stalls;
    logic [CNT_SIZE-1:0] hn;
    logic [W-1:0] hx, hy;
    model(x0, y0);
    @(negedge clk);
    ena = 1'b1; start = 1'b1; x_in = W'(x0); y_in = W'(y0); d_x = 2'b00; d_y = 2'b00;
    @(negedge clk);
    start = 1'b0; c = 1; expn = 1; stalls = 0;
    while (done !== 1'b1 && c < 100) begin
      chk({name, "_n"}, int'(n_out), expn);
      chk({name, "_busy"}, int'(busy), 1);
      if (stall_n == expn && stalls == 0) begin
        hn = n_out; hx = x_out; hy = y_out;
        ena = 1'b0;
        repeat (3) begin
          @(negedge clk); c++;
          chk({name, "_stall_n"}, int'(n_out), int'(hn));
          chk({name, "_stall_x"}, sx(x_out), sx(hx));
          chk({name, "_stall_y"}, sx(y_out), sx(hy));
          chk({name, "_stall_done"}, int'(done), 0);
        end
        ena = 1'b1; stalls = 3;
      end
      if (pulse_n == expn) begin start = 1'b1; x_in = W'($urandom); y_in = W'($urandom); end
      else start = 1'b0;
      d_x = enc(dxa[expn]); d_y = enc(dya[expn]);
      @(negedge clk); c++; expn++;
    end
    start = 1'b0; d_x = 2'b00; d_y = 2'b00;
    chk({name, "_latency"}, c, N + 1 + stalls);
    chk({name, "_x"}, sx(x_out), mx);
    chk({name, "_y"}, sx(y_out), my);
    chk({name, "_ovf"}, int'(ovf), int'(movf));
    chk({name, "_err"}, int'(err), int'(merr));
    chk({name, "_done_busy"}, int'(busy), 0);
    chk({name, "_done_n"}, int'(n_out), 0);
    @(negedge clk);
    chk({name, "_pulse"}, int'(done), 0);
    chk({name, "_idle_busy"}, int'(busy), 0);
    chk({name, "_hold_x"}, sx(x_out), mx);
  endtask

  initial begin
    int c, v;
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; x_in = '0; y_in = '0; d_x = 2'b00; d_y = 2'b00;
    #1;
    chk("rst_n_out", int'(n_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", sx(x_out), 0);
    chk("rst_y", sx(y_out), 0);
    chk("rst_flags", int'({ovf, err}), 0);
    @(negedge clk); rst_n = 1'b1;

    clear_digits();
    run("ident", 64, 16);
    chk("ident_lit_x", sx(x_out), 64);
    chk("ident_lit_y", sx(y_out), 16);

    clear_digits(); dxa[1] = 1;
    run("dxp", 64, 0);
    chk("dxp_lit", sx(x_out), 96);
    dxa[1] = -1;
    run("dxm", 64, 0);
    chk("dxm_lit", sx(x_out), 32);

    clear_digits(); dya[1] = 1;
    run("dy1", 64, 0);
    chk("dy1_lit_y", sx(y_out), 32);
    dya[2] = 1;
    run("dy12", 64, 0);
    chk("dy12_lit_x", sx(x_out), 56);
    chk("dy12_lit_y", sx(y_out), 48);

    clear_digits(); dxa[1] = 1;
    run("sat", 127, 0);
    chk("sat_lit_x", sx(x_out), 127);
    chk("sat_lit_ovf", int'(ovf), 1);

    clear_digits(); dxa[3] = 2;
    run("ill", 50, 30);
    chk("ill_lit_x", sx(x_out), 50);
    chk("ill_lit_err", int'(err), 1);
    chk("ill_ovf_cleared", int'(ovf), 0);

    clear_digits();
    run("clr", 20, -20);
    chk("clr_err", int'(err), 0);

    clear_digits(); dxa[2] = 1; dya[5] = -1; dxa[6] = 1; stall_n = 4; pulse_n = 6;
    run("stall", 40, -24);

    // Mid-run asynchronous reset, asserted between clock edges.
    clear_digits(); dxa[1] = 1; dya[2] = 1;
    @(negedge clk);
    ena = 1'b1; start = 1'b1; x_in = W'(100); y_in = W'(10);
    @(negedge clk); start = 1'b0; c = 0;
    while (n_out != CNT_SIZE'(5) && c < 20) begin
      d_x = enc(dxa[n_out]); d_y = enc(dya[n_out]);
      @(negedge clk); c++;
    end
    chk("rstrun_reach5", int'(n_out), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrun_n", int'(n_out), 0);
    chk("rstrun_busy", int'(busy), 0);
    chk("rstrun_x", sx(x_out), 0);
    chk("rstrun_y", sx(y_out), 0);
    chk("rstrun_flags", int'({done, ovf, err}), 0);
    @(negedge clk); rst_n = 1'b1; d_x = 2'b00; d_y = 2'b00;
    @(negedge clk);
    chk("rstrun_idle", int'(busy), 0);
    run("after_rst", 100, 10);

    for (int r = 0; r < 12; r++) begin
      clear_digits();
      for (int n = 1; n <= N; n++) begin
        v = int'($urandom_range(0, 9));
        dxa[n] = (v == 9) ? 2 : (v % 3) - 1;
        v = int'($urandom_range(0, 9));
        dya[n] = (v == 9) ? 2 : (v % 3) - 1;
      end
      if (r % 4 == 1) stall_n = int'($urandom_range(1, N));
      if (r % 4 == 2) pulse_n = int'($urandom_range(1, N - 1));
      run("rand", int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bkm_e_iter.md
Name: bkm_e_iter

Overview:
- Sequential BKM E-mode iteration engine; consumer of the digit pair produced by the get_d digit selector.
- Loads a complex start value E0 = x_in + j*y_in, then runs N iterations: E(n+1) = E(n) * (1 + (d_x + j*d_y)*2^-n), for n = 1..N.
- Publishes the current index n_out so the digit source can supply d_x/d_y for that iteration in the same cycle.
- Sits between the get_d digit selector and the FPU BKM datapath output register.

Parameters:
- W, 8: data width of x/y operands. Signed two's complement, 2 integer bits (including sign), W-2 fraction bits.
- N, 8: number of iterations. Legal range 1..2^(CNT_SIZE)-1.
- CNT_SIZE, 4: width of the iteration index n_out.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; when low, all state and outputs hold.
- start  in  1  load x_in/y_in and begin iterating; sampled only in IDLE.
- x_in  in  W  signed real part of E0.
- y_in  in  W  signed imaginary part of E0.
- d_x  in  2  signed digit in {-1,0,1} for the current n_out.
- d_y  in  2  signed digit in {-1,0,1} for the current n_out.
- n_out  out  CNT_SIZE  current iteration index; 0 when not in RUN.
- busy  out  1  high in RUN.
- done  out  1  single-cycle pulse when the result is final.
- x_out  out  W  signed real part of the current or final E.
- y_out  out  W  signed imaginary part of the current or final E.
- ovf  out  1  sticky flag: saturation occurred during this run.
- err  out  1  sticky flag: illegal digit 2'b10 received during this run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; n_out=0, busy=0, done=0, x_out=0, y_out=0, ovf=0, err=0. Takes effect immediately, including mid-run; the run is abandoned.
- States: IDLE, RUN, DONE. All transitions require ena=1; with ena=0 nothing changes and done is held low.
- IDLE: when start=1, latch x_out<=x_in, y_out<=y_in; clear ovf and err; set n<=1; go to RUN. start=0: stay in IDLE.
- RUN: each enabled cycle, apply one iteration using d_x, d_y and n=n_out:
  - tx = d_x*x - d_y*y
  - ty = d_y*x + d_x*y
  - Compute tx and ty in W+2 bits. Digit multiplies are select/negate only, with no multiplier.
  - x' = x + (tx >>> n), y' = y + (ty >>> n). The shift is arithmetic (floor) and is applied to the combined term. Sums are computed in W+2 bits.
  - Saturate x' and y' to the W-bit range [-2^(W-1), 2^(W-1)-1]. Any saturation sets ovf.
  - If n==N, go to DONE next cycle; otherwise n<=n+1.
- DONE: done=1 for exactly one cycle; busy=0; n_out=0; go to IDLE. x_out/y_out hold the final value until the next start or reset.
- Illegal digit: d_x or d_y == 2'b10 is treated as 0 for the update and sets err. err is sticky until the next start.
- start while in RUN or DONE is ignored and is not queued.
- Latency: with ena held high, start sampled at edge k gives done high in the cycle after edge k+N, which is N+1 cycles after start.
- The digit inputs are only sampled in RUN.

Test Plan:
- Identity run (W=8, N=8): x_in=8'sh40, y_in=8'sh10, d_x=d_y=0 throughout.
  - Required: done pulses exactly 9 cycles after start; x_out=0x40, y_out=0x10; ovf=0, err=0.
  - busy must be high for exactly 8 cycles, with n_out stepping 1..8.
- Real digit at n=1: x_in=64, y_in=0; d_x=1 at n=1, 0 elsewhere.
  - Required: x_out=96, y_out=0 after the run.
  - Rerun with d_x=-1 at n=1: required x_out=32.
- Imaginary digit at n=1: x_in=64, y_in=0; d_y=1 at n=1, 0 elsewhere.
  - Required: x_out=64, y_out=32.
  - With d_y=1 also at n=2: required x=64-8=56, y=32+16=48.
- Saturation and illegal digit:
  - x_in=127, d_x=1 at n=1: required x_out=127, ovf=1.
  - Separate run with d_x=2'b10 at n=3: required err=1, and result equal to the d_x=0 result.
  - Next start must clear both ovf and err.
- Stall and ignore:
  - Drop ena for 3 cycles at n=4: n_out, x_out, y_out must hold, and done must slip by 3 cycles.
  - Pulse start during RUN: must have no effect.
- Reset mid-run: assert rst_n=0 at n=5, asynchronously between clock edges.
  - Required: all outputs 0 immediately, state IDLE.
  - A fresh start after release must complete normally.
